sprite_fetcher: RTL and testbench

- Responder end of the sprite fetch handshake issued by the OAM evaluation/sprite block.
- On `sprite_fetch` it reads the two tile-row bitplanes from VRAM at the supplied `sprite_addr`, applies X-flip, and merges the 8 pixels into an 8-slot sprite pixel shift buffer.
- It then raises `sprite_fetch_done`.
- Sits between the sprite block, the VRAM arbiter and the pixel mixer inside the video path.

---
 rtl/sprite_pkg.sv | 44 ++++
 rtl/sprite_pix_buf.sv | 65 ++++++
 rtl/sprite_fetcher.sv | 183 ++++++++++++++++++
 tb/tb_sprite_fetcher.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared types and constants for the sprite fetch path.
//   - fetch_state_t   : sprite fetcher FSM states
//   - ATTR_*          : OAM attribute byte bit positions
//   - SPR_BUF_SLOTS   : depth of the sprite pixel shift buffer
//   - spr_slot_t      : one buffer slot {colour, palette, priority}
//   - spr_palette()   : palette select (GBC 3-bit / DMG 1-bit)
// -----------------------------------------------------------------------------
package sprite_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO_RD,
    S_HI_RD,
    S_MERGE,
    S_DONE
  } fetch_state_t;

  localparam int unsigned ATTR_PRIO      = 7;
  localparam int unsigned ATTR_YFLIP     = 6;
  localparam int unsigned ATTR_XFLIP     = 5;
  localparam int unsigned ATTR_DMGPAL    = 4;
  localparam int unsigned ATTR_BANK      = 3;
  localparam int unsigned ATTR_GBCPAL_HI = 2;
  localparam int unsigned ATTR_GBCPAL_LO = 0;

  localparam int unsigned SPR_BUF_SLOTS  = 8;

  localparam logic [3:0]  FETCH_CNT_MAX  = 4'd10;

  typedef struct packed {
    logic [1:0] color;
    logic [2:0] pal;
    logic       prio;
  } spr_slot_t;

  localparam spr_slot_t SLOT_EMPTY = '0;

  function automatic logic [2:0] spr_palette(input logic gbc, input logic [7:0] attr);
    return gbc ? attr[ATTR_GBCPAL_HI:ATTR_GBCPAL_LO] : {2'b00, attr[ATTR_DMGPAL]};
  endfunction

endpackage

// File: rtl/sprite_pix_buf.sv
// -----------------------------------------------------------------------------
// sprite_pix_buf
// 8-slot sprite pixel shift buffer with masked merge.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   ce                  pixel-clock enable
//   clear               empty every slot (takes precedence)
//   shift               move slots toward 0, slot 7 becomes transparent
//   merge               write the new tile row into transparent slots
//   plane_lo, plane_hi  tile row bitplanes
//   xflip               take pixel i from bit i instead of bit 7-i
//   pal, prio           attributes stored with each written slot
//   head                slot 0 (the pixel presented to the mixer)
// -----------------------------------------------------------------------------
module sprite_pix_buf
  import sprite_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       clear,
  input  logic       shift,
  input  logic       merge,
  input  logic [7:0] plane_lo,
  input  logic [7:0] plane_hi,
  input  logic       xflip,
  input  logic [2:0] pal,
  input  logic       prio,
  output spr_slot_t  head
);

  spr_slot_t [SPR_BUF_SLOTS-1:0] slots;
  spr_slot_t [SPR_BUF_SLOTS-1:0] shifted;
  spr_slot_t [SPR_BUF_SLOTS-1:0] nxt;

  // Shift is applied first so a merge in the same cycle lands on the
  // post-shift slots; occupied slots are never overwritten, so earlier
  // fetches keep priority.
  always_comb begin
    shifted = shift ? {SLOT_EMPTY, slots[SPR_BUF_SLOTS-1:1]} : slots;
    nxt     = shifted;
    if (merge) begin
      for (int unsigned i = 0; i < SPR_BUF_SLOTS; i++) begin
        if (shifted[i].color == 2'd0) begin
          nxt[i].color = xflip ? {plane_hi[i], plane_lo[i]}
                               : {plane_hi[SPR_BUF_SLOTS-1-i], plane_lo[SPR_BUF_SLOTS-1-i]};
          nxt[i].pal   = pal;
          nxt[i].prio  = prio;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slots <= '0;
    end else if (ce) begin
      if (clear) slots <= '0;
      else       slots <= nxt;
    end
  end

  assign head = slots[0];

endmodule

// File: rtl/sprite_fetcher.sv
// -----------------------------------------------------------------------------
// sprite_fetcher
// Responder for the sprite fetch handshake: reads the two bitplanes of a
// sprite tile row from VRAM, applies X-flip and merges the pixels into the
// sprite pixel shift buffer, then raises sprite_fetch_done.
// Parameter:
//   VRAM_WAIT   ce-cycles from vram_rd to valid vram_data (1..3)
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   ce                           pixel-clock enable
//   isGBC                        GBC mode (bank select, 3-bit palette)
//   lcd_on, line_start           clear buffer and abort any fetch
//   sprite_fetch, sprite_addr,
//   sprite_attr                  request, {tile,row} address, OAM attribute
//   sprite_fetch_done            fetch complete
//   vram_rd, vram_addr,
//   vram_bank, vram_data         VRAM read port
//   pix_shift                    consume slot 0
//   spr_pix_color/pal/prio       slot 0 pixel
//   fetch_cnt                    merges since last clear, saturating at 10
// Build option:
//   SPRITE_FETCH_CNT_EN          enables fetch_cnt (otherwise tied to 0)
// -----------------------------------------------------------------------------
module sprite_fetcher
  import sprite_pkg::*;
#(
  parameter int unsigned VRAM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        isGBC,
  input  logic        lcd_on,
  input  logic        line_start,
  input  logic        sprite_fetch,
  input  logic [10:0] sprite_addr,
  input  logic [7:0]  sprite_attr,
  output logic        sprite_fetch_done,
  output logic        vram_rd,
  output logic [12:0] vram_addr,
  output logic        vram_bank,
  input  logic [7:0]  vram_data,
  input  logic        pix_shift,
  output logic [1:0]  spr_pix_color,
  output logic [2:0]  spr_pix_pal,
  output logic        spr_pix_prio,
  output logic [3:0]  fetch_cnt
);

  localparam logic [1:0] WAIT_LAST = 2'(VRAM_WAIT - 1);

  fetch_state_t state;
  logic [1:0]   wait_cnt;
  logic [7:0]   lo_q;
  logic [7:0]   hi_q;
  logic         xflip_q;
  logic         prio_q;
  logic [2:0]   pal_q;
  logic         abort;
  logic         merge;
  spr_slot_t    head;

  // Y-flip is resolved upstream in the row part of sprite_addr.
  logic unused_attr;
  assign unused_attr = sprite_attr[ATTR_YFLIP];

  assign abort = line_start | ~lcd_on;
  assign merge = (state == S_MERGE) & sprite_fetch & ~abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      wait_cnt          <= '0;
      lo_q              <= '0;
      hi_q              <= '0;
      xflip_q           <= 1'b0;
      prio_q            <= 1'b0;
      pal_q             <= '0;
      sprite_fetch_done <= 1'b0;
      vram_rd           <= 1'b0;
      vram_addr         <= '0;
      vram_bank         <= 1'b0;
    end else if (ce) begin
      if (abort) begin
        state             <= S_IDLE;
        wait_cnt          <= '0;
        sprite_fetch_done <= 1'b0;
        vram_rd           <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (sprite_fetch) begin
              // vram_addr itself holds the latched tile row address.
              xflip_q   <= sprite_attr[ATTR_XFLIP];
              prio_q    <= sprite_attr[ATTR_PRIO];
              pal_q     <= spr_palette(isGBC, sprite_attr);
              vram_bank <= isGBC & sprite_attr[ATTR_BANK];
              vram_addr <= {1'b0, sprite_addr, 1'b0};
              vram_rd   <= 1'b1;
              wait_cnt  <= '0;
              state     <= S_LO_RD;
            end
          end
          S_LO_RD: begin
            if (!sprite_fetch) begin
              vram_rd <= 1'b0;
              state   <= S_IDLE;
            end else if (wait_cnt == WAIT_LAST) begin
              lo_q         <= vram_data;
              vram_addr[0] <= 1'b1;
              wait_cnt     <= '0;
              state        <= S_HI_RD;
            end else begin
              wait_cnt <= wait_cnt + 2'd1;
            end
          end
          S_HI_RD: begin
            if (!sprite_fetch) begin
              vram_rd <= 1'b0;
              state   <= S_IDLE;
            end else if (wait_cnt == WAIT_LAST) begin
              hi_q     <= vram_data;
              vram_rd  <= 1'b0;
              wait_cnt <= '0;
              state    <= S_MERGE;
            end else begin
              wait_cnt <= wait_cnt + 2'd1;
            end
          end
          S_MERGE: begin
            state <= sprite_fetch ? S_DONE : S_IDLE;
          end
          S_DONE: begin
            if (!sprite_fetch_done) begin
              sprite_fetch_done <= 1'b1;
            end else if (!sprite_fetch) begin
              sprite_fetch_done <= 1'b0;
              state             <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  sprite_pix_buf u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (ce),
    .clear    (abort),
    .shift    (pix_shift),
    .merge    (merge),
    .plane_lo (lo_q),
    .plane_hi (hi_q),
    .xflip    (xflip_q),
    .pal      (pal_q),
    .prio     (prio_q),
    .head     (head)
  );

  assign spr_pix_color = head.color;
  assign spr_pix_pal   = head.pal;
  assign spr_pix_prio  = head.prio;

`ifdef SPRITE_FETCH_CNT_EN
  logic [3:0] fetch_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q <= '0;
    end else if (ce) begin
      if (abort)                                fetch_cnt_q <= '0;
      else if (merge && fetch_cnt_q != FETCH_CNT_MAX) fetch_cnt_q <= fetch_cnt_q + 4'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
`else
  assign fetch_cnt = '0;
`endif

endmodule

// File: tb/tb_sprite_fetcher.sv
module tb_sprite_fetcher;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce;
  logic        isGBC;
  logic        lcd_on;
  logic        line_start;
  logic        sprite_fetch;
  logic [10:0] sprite_addr;
  logic [7:0]  sprite_attr;
  logic        sprite_fetch_done;
  logic        vram_rd;
  logic [12:0] vram_addr;
  logic        vram_bank;
  logic [7:0]  vram_data;
  logic        pix_shift;
  logic [1:0]  spr_pix_color;
  logic [2:0]  spr_pix_pal;
  logic        spr_pix_prio;
  logic [3:0]  fetch_cnt;

  logic [7:0]  lo_m;
  logic [7:0]  hi_m;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // VRAM model: plane selected by address bit 0.
  assign vram_data = vram_addr[0] ? hi_m : lo_m;

  sprite_fetcher #(.VRAM_WAIT(2)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .ce                (ce),
    .isGBC             (isGBC),
    .lcd_on            (lcd_on),
    .line_start        (line_start),
    .sprite_fetch      (sprite_fetch),
    .sprite_addr       (sprite_addr),
    .sprite_attr       (sprite_attr),
    .sprite_fetch_done (sprite_fetch_done),
    .vram_rd           (vram_rd),
    .vram_addr         (vram_addr),
    .vram_bank         (vram_bank),
    .vram_data         (vram_data),
    .pix_shift         (pix_shift),
    .spr_pix_color     (spr_pix_color),
    .spr_pix_pal       (spr_pix_pal),
    .spr_pix_prio      (spr_pix_prio),
    .fetch_cnt         (fetch_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_line();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  // Full handshake; lat = ce-cycles from acceptance to done (0 on timeout).
  task automatic run_fetch(input logic [10:0] a, input logic [7:0] at,
                           input logic [7:0] l, input logic [7:0] h,
                           input bit shift_at_merge,
                           output int lat, output logic [12:0] a0,
                           output logic [12:0] a1, output logic bank);
    int k;
    lo_m = l; hi_m = h;
    sprite_addr = a; sprite_attr = at; sprite_fetch = 1'b1;
    lat = 0; a1 = '0;
    tick();
    a0 = vram_addr; bank = vram_bank;
    k = 1;
    while (k <= 20) begin
      if (shift_at_merge && k == 5) pix_shift = 1'b1;
      tick();
      pix_shift = 1'b0;
      if (k == 3) a1 = vram_addr;
      if (sprite_fetch_done) begin
        lat = k;
        break;
      end
      k++;
    end
    sprite_fetch = 1'b0;
    tick();
  endtask

  // Shift out all 8 slots, checking colour / prio / palette of each.
  task automatic check_buf(input string tag, input logic [15:0] cols,
                           input logic [7:0] prios, input logic [23:0] pals);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s col[%0d]", tag, i), 32'(spr_pix_color), 32'(cols[2*i +: 2]));
      chk($sformatf("%s prio[%0d]", tag, i), 32'(spr_pix_prio), 32'(prios[i]));
      chk($sformatf("%s pal[%0d]", tag, i), 32'(spr_pix_pal), 32'(pals[3*i +: 3]));
      pix_shift = 1'b1;
      tick();
      pix_shift = 1'b0;
    end
  endtask

  initial begin
    int          lat;
    logic [12:0] a0, a1;
    logic        bank;
    int          k;
    logic [3:0]  exp_cnt;

    reset_n = 1'b0; ce = 1'b1; isGBC = 1'b0; lcd_on = 1'b1; line_start = 1'b0;
    sprite_fetch = 1'b0; pix_shift = 1'b0; sprite_addr = '0; sprite_attr = '0;
    lo_m = '0; hi_m = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst done", 32'(sprite_fetch_done), 0);
    chk("rst vram_rd", 32'(vram_rd), 0);
    chk("rst vram_addr", 32'(vram_addr), 0);
    chk("rst vram_bank", 32'(vram_bank), 0);
    chk("rst fetch_cnt", 32'(fetch_cnt), 0);
    chk("rst color", 32'(spr_pix_color), 0);
    reset_n = 1'b1;
    tick();

    // Basic fetch
    run_fetch(11'h123, 8'h00, 8'hF0, 8'hCC, 1'b0, lat, a0, a1, bank);
    chk("basic lo addr", 32'(a0), 32'h246);
    chk("basic hi addr", 32'(a1), 32'h247);
    chk("basic latency", 32'(lat), 6);
    chk("basic done fall", 32'(sprite_fetch_done), 0);
    chk("basic rd drop", 32'(vram_rd), 0);

    // Priority merge on top of the first sprite
    run_fetch(11'h055, 8'h90, 8'hFF, 8'hFF, 1'b0, lat, a0, a1, bank);
    chk("prio latency", 32'(lat), 6);
    chk("prio lo addr", 32'(a0), 32'h0AA);
    check_buf("prio", 16'hFA5F, 8'hC0, 24'h240000);

    // X-flip
    clear_line();
    run_fetch(11'h123, 8'h20, 8'hF0, 8'hCC, 1'b0, lat, a0, a1, bank);
    check_buf("xflip", 16'hF5A0, 8'h00, 24'h000000);

    // GBC bank / palette
    clear_line();
    isGBC = 1'b1;
    run_fetch(11'h010, 8'h0D, 8'hFF, 8'h00, 1'b0, lat, a0, a1, bank);
    chk("gbc bank", 32'(bank), 1);
    chk("gbc pal", 32'(spr_pix_pal), 5);
    chk("gbc color", 32'(spr_pix_color), 1);
    clear_line();
    isGBC = 1'b0;
    run_fetch(11'h010, 8'h0D, 8'hFF, 8'h00, 1'b0, lat, a0, a1, bank);
    chk("dmg bank", 32'(bank), 0);
    chk("dmg pal", 32'(spr_pix_pal), 0);
    chk("dmg color", 32'(spr_pix_color), 1);

    // Abort in HI_RD via line_start, then restart with the request still high
    lo_m = 8'hF0; hi_m = 8'hCC;
    sprite_addr = 11'h123; sprite_attr = 8'h00; sprite_fetch = 1'b1;
    tick();
    chk("abort accept rd", 32'(vram_rd), 1);
    tick();
    tick();
    chk("abort in hi plane", 32'(vram_addr), 32'h247);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    chk("abort rd", 32'(vram_rd), 0);
    chk("abort done", 32'(sprite_fetch_done), 0);
    chk("abort cleared", 32'(spr_pix_color), 0);
    tick();
    chk("restart rd", 32'(vram_rd), 1);
    chk("restart addr", 32'(vram_addr), 32'h246);
    k = 1; lat = 0;
    while (k <= 20) begin
      tick();
      if (sprite_fetch_done) begin
        lat = k;
        break;
      end
      k++;
    end
    chk("restart latency", 32'(lat), 6);
    chk("restart color", 32'(spr_pix_color), 3);
    sprite_fetch = 1'b0;
    tick();

    // Shift in the MERGE cycle: pixel 0 must land in post-shift slot 0
    clear_line();
    run_fetch(11'h001, 8'h00, 8'h80, 8'h00, 1'b1, lat, a0, a1, bank);
    chk("collide latency", 32'(lat), 6);
    chk("collide slot0", 32'(spr_pix_color), 1);

    // Fetch counter saturation and clear by lcd_on=0
    clear_line();
    chk("cnt cleared", 32'(fetch_cnt), 0);
    for (int n = 0; n < 12; n++)
      run_fetch(11'(n), 8'h00, 8'hFF, 8'h00, 1'b0, lat, a0, a1, bank);
`ifdef SPRITE_FETCH_CNT_EN
    exp_cnt = 4'd10;
`else
    exp_cnt = 4'd0;
`endif
    chk("cnt after 12", 32'(fetch_cnt), 32'(exp_cnt));
    chk("pre lcd color", 32'(spr_pix_color), 1);
    lcd_on = 1'b0;
    tick();
    lcd_on = 1'b1;
    chk("lcd off cnt", 32'(fetch_cnt), 0);
    chk("lcd off color", 32'(spr_pix_color), 0);

    // ce gating and request drop mid-fetch
    ce = 1'b0;
    sprite_fetch = 1'b1;
    repeat (3) tick();
    chk("ce hold rd", 32'(vram_rd), 0);
    ce = 1'b1;
    tick();
    chk("ce accept rd", 32'(vram_rd), 1);
    sprite_fetch = 1'b0;
    tick();
    chk("drop abort rd", 32'(vram_rd), 0);
    repeat (8) tick();
    chk("drop no done", 32'(sprite_fetch_done), 0);
    chk("drop no merge", 32'(spr_pix_color), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
